// File: rtl/sm_prog_loader_pkg.sv
// Shared definitions for the stack-machine program loader: state encoding,
// opcode values, default widths and a helper to build instruction words.
package sm_prog_loader_pkg;

  // Default geometry of the stack machine this loader feeds
  localparam int SM_AW       = 10;    // program address width (SM pc)
  localparam int SM_IW       = 13;    // instruction width (SM instr)
  localparam int SM_HDR_ADDR = 1023;  // pc value out of reset, holds the length header
  localparam int SM_DW       = 20;    // SM result width

  // Number of RUN cycles during which fin is not trusted
  localparam int RUN_HOLDOFF = 2;

  // Opcode field occupies the top bits of an instruction word
  localparam int OP_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  typedef enum logic [OP_W-1:0] {
    OP_PUSH = 2'd0,
    OP_ADD  = 2'd1,
    OP_SUB  = 2'd2,
    OP_MUL  = 2'd3
  } opcode_t;

  // Instruction word = {opcode, immediate}; immediate only meaningful for PUSH
  function automatic logic [SM_IW-1:0] mk_instr(input opcode_t op,
                                                input logic [SM_IW-OP_W-1:0] imm);
    return {op, imm};
  endfunction

endpackage

// File: rtl/sm_imem.sv
// Instruction memory for the stack machine: synchronous write port used by
// the loader, asynchronous read port driven by the SM program counter.
// Contents are deliberately not reset so a loaded program survives reset.
module sm_imem #(
  parameter int AW = 10,
  parameter int IW = 13
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [IW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [IW-1:0] rdata
);

  localparam int DEPTH = 1 << AW;

  logic [IW-1:0] mem [DEPTH];

  // Write port: one word per accepted loader beat
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read port is combinational so instr tracks pc within the same cycle
  assign rdata = mem[raddr];

endmodule

// File: rtl/sm_prog_loader.sv
// Program loader and run supervisor for the stack machine. A header beat
// gives the program length L, the next L beats fill mem[0..L-1], and the
// final beat (flagged by wr_last) releases the SM from reset. Results are
// counted while the SM runs; fin (after a short holdoff) ends the run.
module sm_prog_loader
  import sm_prog_loader_pkg::*;
#(
  parameter int AW       = SM_AW,
  parameter int IW       = SM_IW,
  parameter int HDR_ADDR = SM_HDR_ADDR
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [IW-1:0]    wr_data,
  input  logic             wr_last,
  input  logic [AW-1:0]    pc,
  output logic [IW-1:0]    instr,
  output logic             sm_rst_n,
  input  logic             fin,
  input  logic             d_valid,
  input  logic [SM_DW-1:0] out_data,
  output logic             busy,
  output logic             done,
  output logic             load_err,
  output logic [AW-1:0]    res_cnt,
  output logic [SM_DW-1:0] last_res
);

  localparam logic [AW-1:0] HDR_A   = AW'(HDR_ADDR);
  localparam logic [AW-1:0] ONE_A   = AW'(1);
  localparam logic [1:0]    HOLDOFF = 2'(RUN_HOLDOFF);

  state_t             state_reg;
  state_t             state_next;
  logic               err_next;
  logic [AW-1:0]      len_reg;
  logic [AW-1:0]      wcnt_reg;
  logic [1:0]         run_cyc_reg;
  logic               wr_ready_reg;
  logic               sm_rst_n_reg;
  logic               busy_reg;
  logic               done_reg;
  logic               load_err_reg;
  logic [AW-1:0]      res_cnt_reg;
  logic [SM_DW-1:0]   last_res_reg;

  logic               accept;
  logic               hdr_beat;
  logic               load_beat;
  logic [AW-1:0]      hdr_len;
  logic               hdr_bad;
  logic               beat_final;
  logic               mem_we;
  logic [AW-1:0]      mem_waddr;

  // Beat qualification; RUN never accepts since wr_ready is low there
  always_comb begin
    accept     = wr_valid && wr_ready_reg && (state_reg != ST_RUN);
    hdr_beat   = accept && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));
    load_beat  = accept && (state_reg == ST_LOAD);
    hdr_len    = wr_data[AW-1:0];
    hdr_bad    = (hdr_len == '0) || (hdr_len >= HDR_A) || wr_last;
    beat_final = (wcnt_reg == (len_reg - ONE_A));
    mem_we     = hdr_beat || load_beat;
    mem_waddr  = hdr_beat ? HDR_A : wcnt_reg;
  end

  // Next-state and error-pulse decision for the loader FSM
  always_comb begin
    state_next = state_reg;
    err_next   = 1'b0;
    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (hdr_beat) begin
          if (hdr_bad) begin
            state_next = ST_IDLE;
            err_next   = 1'b1;
          end else begin
            state_next = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        if (load_beat) begin
          if (beat_final != wr_last) begin
            state_next = ST_IDLE;
            err_next   = 1'b1;
          end else if (beat_final) begin
            state_next = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if ((run_cyc_reg == HOLDOFF) && fin) begin
          state_next = ST_DONE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // FSM state, registered outputs, write counter and result tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      len_reg      <= '0;
      wcnt_reg     <= '0;
      run_cyc_reg  <= '0;
      wr_ready_reg <= 1'b0;
      sm_rst_n_reg <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      load_err_reg <= 1'b0;
      res_cnt_reg  <= '0;
      last_res_reg <= '0;
    end else begin
      state_reg    <= state_next;
      wr_ready_reg <= (state_next != ST_RUN);
      sm_rst_n_reg <= (state_next == ST_RUN);
      busy_reg     <= (state_next == ST_LOAD) || (state_next == ST_RUN);
      done_reg     <= (state_next == ST_DONE);
      load_err_reg <= err_next;

      if (hdr_beat) begin
        len_reg  <= hdr_len;
        wcnt_reg <= '0;
      end else if (load_beat) begin
        wcnt_reg <= wcnt_reg + ONE_A;
      end

      // Holdoff counter restarts on every entry into RUN
      if ((state_reg != ST_RUN) && (state_next == ST_RUN)) begin
        run_cyc_reg <= '0;
      end else if ((state_reg == ST_RUN) && (run_cyc_reg != HOLDOFF)) begin
        run_cyc_reg <= run_cyc_reg + 2'd1;
      end

      // A header always starts a fresh result record
      if (hdr_beat) begin
        res_cnt_reg  <= '0;
        last_res_reg <= '0;
      end else if ((state_reg == ST_RUN) && d_valid) begin
        if (!(&res_cnt_reg)) begin
          res_cnt_reg <= res_cnt_reg + ONE_A;
        end
        last_res_reg <= out_data;
      end
    end
  end

  sm_imem #(
    .AW(AW),
    .IW(IW)
  ) u_imem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (wr_data),
    .raddr (pc),
    .rdata (instr)
  );

  assign wr_ready = wr_ready_reg;
  assign sm_rst_n = sm_rst_n_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;
  assign load_err = load_err_reg;
  assign res_cnt  = res_cnt_reg;
  assign last_res = last_res_reg;

endmodule

// File: tb/tb_sm_prog_loader.sv
// Directed bench for sm_prog_loader: loads small programs, plays the SM side
// (fin, d_valid, out_data) by hand and checks loader outputs against
// hand-computed values.
module tb_sm_prog_loader;
  import sm_prog_loader_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        wr_valid;
  logic        wr_ready;
  logic [12:0] wr_data;
  logic        wr_last;
  logic [9:0]  pc;
  logic [12:0] instr;
  logic        sm_rst_n;
  logic        fin;
  logic        d_valid;
  logic [19:0] out_data;
  logic        busy;
  logic        done;
  logic        load_err;
  logic [9:0]  res_cnt;
  logic [19:0] last_res;

  int total;
  int bad;

  sm_prog_loader dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_data  (wr_data),
    .wr_last  (wr_last),
    .pc       (pc),
    .instr    (instr),
    .sm_rst_n (sm_rst_n),
    .fin      (fin),
    .d_valid  (d_valid),
    .out_data (out_data),
    .busy     (busy),
    .done     (done),
    .load_err (load_err),
    .res_cnt  (res_cnt),
    .last_res (last_res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One accepted loader beat; returns 1 time unit after the accepting edge
  task automatic beat(input logic [12:0] d, input logic l);
    wr_valid = 1'b1;
    wr_data  = d;
    wr_last  = l;
    tick();
    wr_valid = 1'b0;
    wr_last  = 1'b0;
    $display("beat data=%h last=%0b busy=%0b err=%0b", d, l, busy, load_err);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL rst_wr_ready got=%0b want=0", wr_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%0b want=0", done); end
    total++; if (sm_rst_n !== 1'b0) begin bad++; $display("FAIL rst_sm_rst_n got=%0b want=0", sm_rst_n); end
    total++; if (load_err !== 1'b0) begin bad++; $display("FAIL rst_load_err got=%0b want=0", load_err); end
    total++; if (res_cnt !== 10'd0) begin bad++; $display("FAIL rst_res_cnt got=%0d want=0", res_cnt); end
    total++; if (last_res !== 20'd0) begin bad++; $display("FAIL rst_last_res got=%h want=0", last_res); end
    rst_n = 1'b1;
    tick();
    total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL rst_rel_wr_ready got=%0b want=1", wr_ready); end
    $display("reset released wr_ready=%0b", wr_ready);
  endtask

  // Header 3, PUSH 5, PUSH 7, ADD, one result, fin with holdoff
  task automatic test_basic_run();
    beat(13'd3, 1'b0);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_load_busy got=%0b want=1", busy); end
    total++; if (sm_rst_n !== 1'b0) begin bad++; $display("FAIL basic_load_smrst got=%0b want=0", sm_rst_n); end
    beat(mk_instr(OP_PUSH, 11'd5), 1'b0);
    beat(mk_instr(OP_PUSH, 11'd7), 1'b0);
    total++; if (sm_rst_n !== 1'b0) begin bad++; $display("FAIL basic_mid_smrst got=%0b want=0", sm_rst_n); end
    beat(mk_instr(OP_ADD, 11'd0), 1'b1);
    total++; if (sm_rst_n !== 1'b1) begin bad++; $display("FAIL basic_run_smrst got=%0b want=1", sm_rst_n); end
    total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL basic_run_ready got=%0b want=0", wr_ready); end
    pc = 10'd1023; #1;
    total++; if (instr !== 13'd3) begin bad++; $display("FAIL basic_hdr_mem got=%h want=%h", instr, 13'd3); end
    pc = 10'd0; #1;
    total++; if (instr !== 13'h0005) begin bad++; $display("FAIL basic_mem0 got=%h want=0005", instr); end
    pc = 10'd2; #1;
    total++; if (instr !== 13'h0800) begin bad++; $display("FAIL basic_mem2 got=%h want=0800", instr); end
    // RUN cycle 0: one result
    d_valid = 1'b1; out_data = 20'd12;
    tick();
    d_valid = 1'b0;
    total++; if (res_cnt !== 10'd1) begin bad++; $display("FAIL basic_res_cnt got=%0d want=1", res_cnt); end
    total++; if (last_res !== 20'd12) begin bad++; $display("FAIL basic_last_res got=%h want=0000c", last_res); end
    // RUN cycle 1: fin still inside holdoff
    fin = 1'b1;
    tick();
    total++; if (sm_rst_n !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL basic_holdoff got=smrst%0b/done%0b want=1/0", sm_rst_n, done); end
    // RUN cycle 2: fin honoured
    tick();
    fin = 1'b0;
    total++; if (done !== 1'b1) begin bad++; $display("FAIL basic_done got=%0b want=1", done); end
    total++; if (busy !== 1'b0 || sm_rst_n !== 1'b0) begin bad++; $display("FAIL basic_done_outs got=busy%0b/smrst%0b want=0/0", busy, sm_rst_n); end
    d_valid = 1'b1; out_data = 20'd99;
    tick();
    d_valid = 1'b0;
    total++; if (res_cnt !== 10'd1 || last_res !== 20'd12) begin bad++; $display("FAIL basic_done_hold got=%0d/%h want=1/0000c", res_cnt, last_res); end
    $display("basic run res_cnt=%0d last_res=%h", res_cnt, last_res);
  endtask

  // Length mismatch: wr_last too early, and wr_last missing on final beat
  task automatic test_last_errors();
    beat(13'd2, 1'b0);
    total++; if (res_cnt !== 10'd0 || last_res !== 20'd0) begin bad++; $display("FAIL early_hdr_clear got=%0d/%h want=0/0", res_cnt, last_res); end
    beat(mk_instr(OP_PUSH, 11'd1), 1'b1);
    total++; if (load_err !== 1'b1) begin bad++; $display("FAIL early_err got=%0b want=1", load_err); end
    total++; if (busy !== 1'b0 || done !== 1'b0 || wr_ready !== 1'b1) begin bad++; $display("FAIL early_idle got=b%0b d%0b r%0b want=0/0/1", busy, done, wr_ready); end
    total++; if (sm_rst_n !== 1'b0) begin bad++; $display("FAIL early_smrst got=%0b want=0", sm_rst_n); end
    tick();
    total++; if (load_err !== 1'b0) begin bad++; $display("FAIL early_pulse got=%0b want=0", load_err); end
    total++; if (sm_rst_n !== 1'b0) begin bad++; $display("FAIL early_smrst2 got=%0b want=0", sm_rst_n); end
    beat(13'd2, 1'b0);
    beat(mk_instr(OP_PUSH, 11'd1), 1'b0);
    total++; if (load_err !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL nolast_mid got=e%0b b%0b want=0/1", load_err, busy); end
    beat(mk_instr(OP_PUSH, 11'd2), 1'b0);
    total++; if (load_err !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL nolast_err got=e%0b b%0b want=1/0", load_err, busy); end
  endtask

  // Header boundaries: 0, 1023 and a header carrying wr_last are rejected, 1022 accepted
  task automatic test_bad_header();
    beat(13'd0, 1'b0);
    total++; if (load_err !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL hdr0 got=e%0b b%0b d%0b want=1/0/0", load_err, busy, done); end
    tick();
    beat(13'd1023, 1'b0);
    total++; if (load_err !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL hdr1023 got=e%0b b%0b d%0b want=1/0/0", load_err, busy, done); end
    tick();
    beat(13'd5, 1'b1);
    total++; if (load_err !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL hdr_last got=e%0b b%0b want=1/0", load_err, busy); end
    beat(13'd1022, 1'b0);
    total++; if (load_err !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL hdr1022 got=e%0b b%0b want=0/1", load_err, busy); end
    beat(mk_instr(OP_PUSH, 11'd1), 1'b1);
    total++; if (load_err !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL hdr1022_abort got=e%0b b%0b want=1/0", load_err, busy); end
  endtask

  // Writes during RUN are ignored, then an asynchronous reset aborts the run
  task automatic test_run_ignore_and_reset();
    beat(13'd2, 1'b0);
    beat(mk_instr(OP_PUSH, 11'd9), 1'b0);
    beat(mk_instr(OP_SUB, 11'd0), 1'b1);
    wr_valid = 1'b1; wr_data = 13'h1FFF; wr_last = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++; if (wr_ready !== 1'b0 || load_err !== 1'b0 || sm_rst_n !== 1'b1) begin bad++; $display("FAIL run_ignore cyc=%0d got=r%0b e%0b s%0b want=0/0/1", i, wr_ready, load_err, sm_rst_n); end
      tick();
    end
    wr_valid = 1'b0; wr_last = 1'b0;
    pc = 10'd0; #1;
    total++; if (instr !== 13'h0009) begin bad++; $display("FAIL run_ignore_mem0 got=%h want=0009", instr); end
    pc = 10'd1; #1;
    total++; if (instr !== 13'h1000) begin bad++; $display("FAIL run_ignore_mem1 got=%h want=1000", instr); end
    pc = 10'd1023; #1;
    total++; if (instr !== 13'd2) begin bad++; $display("FAIL run_ignore_hdr got=%h want=0002", instr); end
    tick();
    d_valid = 1'b1; out_data = 20'h00042;
    tick();
    d_valid = 1'b0;
    total++; if (res_cnt !== 10'd1) begin bad++; $display("FAIL prerst_res_cnt got=%0d want=1", res_cnt); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (sm_rst_n !== 1'b0 || busy !== 1'b0 || wr_ready !== 1'b0) begin bad++; $display("FAIL midrun_rst got=s%0b b%0b r%0b want=0/0/0", sm_rst_n, busy, wr_ready); end
    total++; if (res_cnt !== 10'd0 || last_res !== 20'd0) begin bad++; $display("FAIL midrun_rst_res got=%0d/%h want=0/0", res_cnt, last_res); end
    rst_n = 1'b1;
    tick();
    total++; if (wr_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL postrst_idle got=r%0b b%0b d%0b want=1/0/0", wr_ready, busy, done); end
    pc = 10'd0; #1;
    total++; if (instr !== 13'h0009) begin bad++; $display("FAIL postrst_mem got=%h want=0009", instr); end
  endtask

  // PUSH -3, PUSH 4, MUL; final result arrives together with fin
  task automatic test_mul_and_reload();
    beat(13'd3, 1'b0);
    beat(mk_instr(OP_PUSH, 11'h7FD), 1'b0);
    beat(mk_instr(OP_PUSH, 11'd4), 1'b0);
    beat(mk_instr(OP_MUL, 11'd0), 1'b1);
    pc = 10'd0; #1;
    total++; if (instr !== 13'h07FD) begin bad++; $display("FAIL mul_mem0 got=%h want=07fd", instr); end
    pc = 10'd2; #1;
    total++; if (instr !== 13'h1800) begin bad++; $display("FAIL mul_mem2 got=%h want=1800", instr); end
    d_valid = 1'b1; out_data = 20'hFFFFD;
    tick();
    out_data = 20'h00004;
    tick();
    out_data = 20'hFFFF4; fin = 1'b1;
    tick();
    d_valid = 1'b0; fin = 1'b0;
    total++; if (done !== 1'b1) begin bad++; $display("FAIL mul_done got=%0b want=1", done); end
    total++; if (res_cnt !== 10'd3) begin bad++; $display("FAIL mul_res_cnt got=%0d want=3", res_cnt); end
    total++; if (last_res !== 20'hFFFF4) begin bad++; $display("FAIL mul_last_res got=%h want=ffff4", last_res); end
    beat(13'd2, 1'b0);
    total++; if (busy !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL reload_load got=b%0b d%0b want=1/0", busy, done); end
    total++; if (res_cnt !== 10'd0 || last_res !== 20'd0) begin bad++; $display("FAIL reload_clear got=%0d/%h want=0/0", res_cnt, last_res); end
  endtask

  // Continues the reload: res_cnt saturates at all-ones
  task automatic test_saturate();
    beat(mk_instr(OP_PUSH, 11'd1), 1'b0);
    beat(mk_instr(OP_ADD, 11'd0), 1'b1);
    d_valid = 1'b1; out_data = 20'h00001;
    for (int i = 0; i < 1030; i++) begin
      tick();
    end
    d_valid = 1'b0;
    total++; if (res_cnt !== 10'h3FF) begin bad++; $display("FAIL sat_res_cnt got=%0d want=1023", res_cnt); end
    fin = 1'b1;
    tick();
    fin = 1'b0;
    total++; if (done !== 1'b1 || res_cnt !== 10'h3FF) begin bad++; $display("FAIL sat_done got=d%0b c%0d want=1/1023", done, res_cnt); end
    $display("saturate res_cnt=%0d", res_cnt);
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    rst_n    = 1'b0;
    wr_valid = 1'b0;
    wr_data  = '0;
    wr_last  = 1'b0;
    pc       = '0;
    fin      = 1'b0;
    d_valid  = 1'b0;
    out_data = '0;
    test_reset();
    test_basic_run();
    test_last_errors();
    test_bad_header();
    test_run_ignore_and_reset();
    test_mul_and_reload();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sm_prog_loader.md
SM_PROG_LOADER -- requirements
Module: sm_prog_loader

Interface
REQ-001 Parameter AW, default 10, SHALL set the program address width, matching the SM pc.
REQ-002 Parameter IW, default 13, SHALL set the instruction width, matching the SM instr.
REQ-003 Parameter HDR_ADDR, default 1023, SHALL set the address that holds the length header, which is the SM pc value out of reset.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  reset; one clock, asynchronous and active-low.
REQ-006 wr_valid  input  1  loader beat valid.
REQ-007 wr_ready  output  1  loader beat accepted when wr_valid and wr_ready are both high on a rising edge.
REQ-008 wr_data  input  IW  header or instruction word.
REQ-009 wr_last  input  1  marks the final program beat.
REQ-010 pc  input  AW  SM program counter.
REQ-011 instr  output  IW  instruction to the SM.
REQ-012 sm_rst_n  output  1  registered reset to the SM; low holds the SM in reset.
REQ-013 fin  input  1  SM program-finished flag.
REQ-014 d_valid  input  1  SM result-valid flag.
REQ-015 out_data  input  20  SM result.
REQ-016 busy  output  1  high in LOAD or RUN.
REQ-017 done  output  1  high in DONE.
REQ-018 load_err  output  1  one-cycle error pulse.
REQ-019 res_cnt  output  AW  count of accepted results.
REQ-020 last_res  output  20  most recent result.

Function
REQ-021 The FSM SHALL have four states, IDLE, LOAD, RUN and DONE, and SHALL enter IDLE on reset.
REQ-022 wr_ready SHALL be high in IDLE, LOAD and DONE, and low in RUN.
REQ-023 In IDLE or DONE, an accepted beat is the header: L = wr_data[AW-1:0].
REQ-024 The header SHALL be written to mem[HDR_ADDR], clear res_cnt and last_res, and move the FSM to LOAD.
REQ-025 A header with L=0 or L>=HDR_ADDR SHALL pulse load_err and move the FSM to IDLE.
REQ-026 A header beat that also carries wr_last SHALL pulse load_err and move the FSM to IDLE.
REQ-027 In LOAD, the k-th accepted beat (k=0..L-1) SHALL be written to mem[k], with the write counter incrementing on each beat.
REQ-028 The beat with k=L-1 and wr_last=1 SHALL move the FSM to RUN.
REQ-029 wr_last with k<L-1, or no wr_last at k=L-1, SHALL pulse load_err and move the FSM to IDLE; the memory contents are then don't-care.
REQ-030 instr SHALL equal mem[pc] combinationally, in every state.
REQ-031 sm_rst_n SHALL be high exactly in RUN and SHALL rise on the first RUN cycle.
REQ-032 In RUN, on each cycle with d_valid=1: res_cnt += 1 (saturating at all-ones) and last_res <= out_data.
REQ-033 fin SHALL be ignored for the first 2 RUN cycles.
REQ-034 After those first 2 RUN cycles, fin=1 SHALL move the FSM to DONE on the next edge.
REQ-035 A d_valid in the same cycle as fin SHALL still be counted.
REQ-036 In DONE, res_cnt and last_res SHALL hold their values.
REQ-037 In DONE, a new header beat SHALL start a new load, with the same rules as in IDLE.
REQ-038 wr_valid during RUN SHALL be ignored (no write, no error).

Reset
REQ-039 While rst_n is low, asynchronously: state=IDLE, sm_rst_n=0, wr_ready=0, busy=0, done=0, load_err=0, res_cnt=0, last_res=0, and the write counter is 0.
REQ-040 wr_ready SHALL go high on the first edge after rst_n deasserts.
REQ-041 Memory contents SHALL not be reset.
REQ-042 Reset mid-LOAD or mid-RUN SHALL abort immediately, and the program SHALL be treated as lost.

Structure
REQ-043 A shared package SHALL hold the FSM state encoding, the opcodes PUSH=0, ADD=1, SUB=2, MUL=3, HDR_ADDR, and the widths AW, IW and 20.
REQ-044 The block SHALL have one sub-module, sm_imem: a 2^AW x IW array with synchronous write and asynchronous read, and no reset.

Verification
REQ-045 The bench SHALL cover this scenario: header 3, beats {PUSH 5, PUSH 7, ADD+last} -> RUN, mem[1023]=3, one d_valid with out_data=12, then fin -> DONE, res_cnt=1, last_res=12.
REQ-046 The bench SHALL cover this scenario: header 2, then wr_last on the first beat -> load_err pulse, IDLE, sm_rst_n stays 0.
REQ-047 The bench SHALL cover this scenario: header 0, and separately header 1023 -> load_err, IDLE, no state change.
REQ-048 The bench SHALL cover this scenario: wr_valid asserted throughout RUN -> wr_ready=0, and mem[0..L-1] unchanged.
REQ-049 The bench SHALL cover this scenario: a program of PUSH -3, PUSH 4, MUL -> last_res=20'hFFFF4, and a new header in DONE -> LOAD, res_cnt=0.
REQ-050 The bench SHALL cover this scenario: rst_n low mid-RUN -> sm_rst_n=0 immediately, state IDLE, res_cnt=0.
